// File: rtl/counter_trace_decoder.sv
// Decodes a sampled up/down/load counter stream into per-sample step events.
// Optional HOLD-run stall detection is enabled with `define COUNTER_TRACE_STALL_EN.
module counter_trace_decoder #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned RUN_W       = 8,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             step_valid,
  output logic [1:0]       step_kind,
  output logic             dir_up,
  output logic             load_seen,
  output logic [WIDTH-1:0] load_value,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [RUN_W-1:0] run_len,
  output logic             locked,
  output logic             stalled
);

  if (WIDTH < 2 || WIDTH > 16 || RUN_W < 1 || STALL_LIMIT < 1) begin : g_param_check
    $error("counter_trace_decoder: illegal parameter value");
  end

  typedef enum logic {StIdle, StTrack} state_e;

  localparam logic [1:0] KindHold = 2'b00;
  localparam logic [1:0] KindUp   = 2'b01;
  localparam logic [1:0] KindDown = 2'b10;
  localparam logic [1:0] KindLoad = 2'b11;

  localparam logic [WIDTH-1:0] WOne = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] ROne = {{(RUN_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;
  logic [1:0]       kind_d;
  logic [RUN_W-1:0] run_inc;

  // Modulo-2^WIDTH difference falls out of the fixed-width subtraction.
  assign diff = count_in - prev_q;

  always_comb begin
    kind_d = KindLoad;
    if (diff == '0) begin
      kind_d = KindHold;
    end else if (diff == WOne) begin
      kind_d = KindUp;
    end else if (diff == '1) begin
      kind_d = KindDown;
    end
  end

  assign run_inc = (run_len == '1) ? run_len : run_len + ROne;
  assign locked  = (state_q == StTrack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      step_valid <= 1'b0;
      step_kind  <= KindHold;
      dir_up     <= 1'b0;
      load_seen  <= 1'b0;
      load_value <= '0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      run_len    <= '0;
    end else begin
      step_valid <= 1'b0;
      load_seen  <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      if (in_valid) begin
        prev_q <= count_in;
        unique case (state_q)
          StIdle: state_q <= StTrack;
          StTrack: begin
            step_valid <= 1'b1;
            step_kind  <= kind_d;
            unique case (kind_d)
              KindUp: begin
                dir_up  <= 1'b1;
                run_len <= dir_up ? run_inc : ROne;
                wrap_up <= (prev_q == '1);
              end
              KindDown: begin
                dir_up    <= 1'b0;
                run_len   <= dir_up ? ROne : run_inc;
                wrap_down <= (prev_q == '0);
              end
              KindLoad: begin
                load_seen  <= 1'b1;
                load_value <= count_in;
                run_len    <= '0;
              end
              default: ;
            endcase
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef COUNTER_TRACE_STALL_EN
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);

  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && state_q == StTrack) begin
      if (kind_d == KindHold) begin
        if (stall_cnt_q != StallMax) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end else begin
        stall_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      stalled     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stalled     <= (stall_cnt_d == StallMax);
    end
  end
`else
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_counter_trace_decoder.sv
// Randomized and directed bench for counter_trace_decoder against an arithmetic reference model.
module tb_counter_trace_decoder;

  localparam int W    = 6;
  localparam int RW   = 8;
  localparam int SL   = 16;
  localparam int MAXV = (1 << W) - 1;
  localparam int RMAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  count_in = '0;
  logic          step_valid;
  logic [1:0]    step_kind;
  logic          dir_up;
  logic          load_seen;
  logic [W-1:0]  load_value;
  logic          wrap_up;
  logic          wrap_down;
  logic [RW-1:0] run_len;
  logic          locked;
  logic          stalled;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_locked;
  int m_prev, m_dir, m_run, m_lv, m_kind, m_hold;
  bit m_sv, m_ls, m_wu, m_wd;

  counter_trace_decoder #(
    .WIDTH      (W),
    .RUN_W      (RW),
    .STALL_LIMIT(SL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .count_in  (count_in),
    .step_valid(step_valid),
    .step_kind (step_kind),
    .dir_up    (dir_up),
    .load_seen (load_seen),
    .load_value(load_value),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down),
    .run_len   (run_len),
    .locked    (locked),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 0; m_prev = 0; m_dir = 0; m_run = 0; m_lv = 0; m_kind = 0; m_hold = 0;
    m_sv = 0; m_ls = 0; m_wu = 0; m_wd = 0;
  endtask

  task automatic model_step(input bit valid, input int v);
    int d;
    m_sv = 0; m_ls = 0; m_wu = 0; m_wd = 0;
    if (!valid) return;
    if (!m_locked) begin
      m_locked = 1;
      m_prev   = v;
      return;
    end
    d = (v - m_prev + MAXV + 1) % (MAXV + 1);
    m_sv = 1;
    if (d == 0) begin
      m_kind = 0;
      m_hold = (m_hold < SL) ? m_hold + 1 : SL;
    end else begin
      m_hold = 0;
      if (d == 1) begin
        m_kind = 1;
        m_wu   = (m_prev == MAXV);
        m_run  = (m_dir == 1) ? ((m_run < RMAX) ? m_run + 1 : RMAX) : 1;
        m_dir  = 1;
      end else if (d == MAXV) begin
        m_kind = 2;
        m_wd   = (m_prev == 0);
        m_run  = (m_dir == 0) ? ((m_run < RMAX) ? m_run + 1 : RMAX) : 1;
        m_dir  = 0;
      end else begin
        m_kind = 3;
        m_ls   = 1;
        m_lv   = v;
        m_run  = 0;
      end
    end
    m_prev = v;
  endtask

  function automatic bit model_stalled();
`ifdef COUNTER_TRACE_STALL_EN
    return m_hold == SL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".step_valid"}, 32'(step_valid), 32'(m_sv));
    chk({tag, ".step_kind"},  32'(step_kind),  32'(m_kind));
    chk({tag, ".dir_up"},     32'(dir_up),     32'(m_dir));
    chk({tag, ".load_seen"},  32'(load_seen),  32'(m_ls));
    chk({tag, ".load_value"}, 32'(load_value), 32'(m_lv));
    chk({tag, ".wrap_up"},    32'(wrap_up),    32'(m_wu));
    chk({tag, ".wrap_down"},  32'(wrap_down),  32'(m_wd));
    chk({tag, ".run_len"},    32'(run_len),    32'(m_run));
    chk({tag, ".locked"},     32'(locked),     32'(m_locked));
    chk({tag, ".stalled"},    32'(stalled),    32'(model_stalled()));
  endtask

  task automatic drive(input string tag, input bit valid, input int v);
    @(negedge clk);
    in_valid = valid;
    count_in = W'(v);
    @(posedge clk);
    #1;
    model_step(valid, v);
    check_all(tag);
  endtask

  // Reset is asserted between clock edges to exercise the asynchronous path.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cur;
    int r;
    bit vld;
    model_reset();
    #1;
    check_all("por");
    @(negedge clk);
    rst = 1'b1;

    // Up run from a fresh seed
    drive("seed12", 1, 12);
    drive("up13", 1, 13);
    drive("up14", 1, 14);
    drive("up15", 1, 15);
    // Jump then down run
    drive("ld20", 1, 20);
    drive("dn19", 1, 19);
    drive("dn18", 1, 18);
    // Load check
    drive("ld5", 1, 5);
    drive("ld40", 1, 40);
    drive("gap0", 0, 0);
    // Wrap boundaries
    drive("ld62", 1, 62);
    drive("up63", 1, 63);
    drive("wrapup", 1, 0);
    drive("wrapdn", 1, 63);
    // Holds separated by gaps
    drive("ld7", 1, 7);
    drive("gap1", 0, 9);
    drive("hold7", 1, 7);
    drive("gap2", 0, 3);
    drive("gap3", 0, 8);
    drive("up8", 1, 8);
    // Long hold run crosses the stall limit
    for (int i = 0; i < SL + 3; i++) drive("holdrun", 1, 8);
    drive("unstall", 1, 9);
    // Mid-run reset
    drive("v30", 1, 30);
    do_reset("midrst");
    drive("reseed31", 1, 31);
    drive("up32", 1, 32);
    // Run length saturation
    cur = 32;
    for (int i = 0; i < RMAX + 4; i++) begin
      cur = (cur + 1) & MAXV;
      drive("satup", 1, cur);
    end
    drive("satrev", 1, (cur - 1) & MAXV);
    cur = (cur - 1) & MAXV;

    // Random stream biased toward steps
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset("rndrst");
      end
      r   = int'($urandom_range(0, 9));
      vld = ($urandom_range(0, 3) != 0);
      if (r < 4)      cur = (cur + 1) & MAXV;
      else if (r < 7) cur = (cur - 1) & MAXV;
      else if (r < 8) cur = cur;
      else            cur = int'($urandom_range(0, MAXV));
      drive("rnd", vld, cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
